// File: rtl/ercm8_7.sv
// ercm8_7: 8x8 approximate multiplier, mask ORs columns 0..6 carry-free; ERCM_INPUT_REG_EN adds an input register stage
module ercm8_7 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dat_in_a,
  input  logic [7:0]  dat_in_b,
  input  logic [6:0]  mask,
  output logic [15:0] dat_o
);
  logic [7:0]  a, b;
  logic [6:0]  m;
  logic [14:0] mx;
  logic [15:0] s, v;
`ifdef ERCM_INPUT_REG_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {a, b, m} <= '0;
    else {a, b, m} <= {dat_in_a, dat_in_b, mask};
`else
  assign a = dat_in_a;
  assign b = dat_in_b;
  assign m = mask;
`endif
  assign mx = {8'b0, m};
  always_comb begin
    s = '0;
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (mx[i+j]) v[i+j] = v[i+j] | (a[j] & b[i]);
        else s = s + (16'(a[j] & b[i]) << (i + j));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dat_o <= '0;
    else dat_o <= s | v;
endmodule

// File: tb/tb_ercm8_7.sv
// tb_ercm8_7: directed table, reset sequences and random exact/bound checks for ercm8_7
module tb_ercm8_7;
  localparam int LAT = `ifdef ERCM_INPUT_REG_EN 2 `else 1 `endif;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  m;
    logic [15:0] exp;
  } vec_t;
  logic        clk = 0;
  logic        rst_n = 1;
  logic [7:0]  a = 8'hFF, b = 8'hFF;
  logic [6:0]  mask = 0;
  logic [15:0] dat_o;
  int          n_vec = 0, n_bad = 0;
  vec_t        tbl[12];
  logic [7:0]  sa[10000], sb[10000];
  logic [6:0]  sm[10000];
  logic [15:0] se[10000];
  bit          sx[10000];
  int          errs, err7f;
  ercm8_7 dut (.clk(clk), .rst_n(rst_n), .dat_in_a(a), .dat_in_b(b), .mask(mask), .dat_o(dat_o));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: dat_o=%0d expected %0d", name, act, req);
    end
  endtask
  task automatic run(input int n, input string name, output int e);
    int j;
    e = 0;
    for (int i = 0; i < n + LAT - 1; i++) begin
      @(negedge clk);
      if (i < n) begin
        a = sa[i];
        b = sb[i];
        mask = sm[i];
      end
      @(posedge clk);
      #1;
      j = i - LAT + 1;
      if (j >= 0) begin
        if (sx[j]) check(name, dat_o, se[j]);
        else begin
          n_vec++;
          if (dat_o > se[j]) begin
            n_bad++;
            $display("FAIL %s: a=%0d b=%0d mask=%h dat_o=%0d exceeds exact %0d", name, sa[j], sb[j], sm[j], dat_o, se[j]);
          end
        end
        if (dat_o != se[j]) e++;
      end
    end
  endtask
  initial begin
    tbl[0]  = '{8'd255, 8'd255, 7'h00, 16'd65025};
    tbl[1]  = '{8'd13,  8'd200, 7'h00, 16'd2600};
    tbl[2]  = '{8'd255, 8'd255, 7'h7F, 16'hFB7F};
    tbl[3]  = '{8'd3,   8'd3,   7'h02, 16'd7};
    tbl[4]  = '{8'd1,   8'd200, 7'h7F, 16'd200};
    tbl[5]  = '{8'd0,   8'd255, 7'h7F, 16'd0};
    tbl[6]  = '{8'd3,   8'd3,   7'h04, 16'd5};
    tbl[7]  = '{8'd3,   8'd3,   7'h01, 16'd9};
    tbl[8]  = '{8'd255, 8'd255, 7'h40, 16'hFC41};
    tbl[9]  = '{8'd255, 8'd255, 7'h03, 16'hFDFF};
    tbl[10] = '{8'd7,   8'd7,   7'h07, 16'd39};
    tbl[11] = '{8'd200, 8'd1,   7'h7F, 16'd200};
    #2 rst_n = 0;
    #1 check("reset_async", dat_o, 16'd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_hold", dat_o, 16'd0);
    end
    @(negedge clk) rst_n = 1;
    repeat (LAT) @(posedge clk);
    #1 check("reset_release", dat_o, 16'd65025);
    for (int i = 0; i < 12; i++) begin
      sa[i] = tbl[i].a;
      sb[i] = tbl[i].b;
      sm[i] = tbl[i].m;
      se[i] = tbl[i].exp;
      sx[i] = 1;
    end
    run(12, "table", errs);
    @(negedge clk);
    a = 200;
    b = 100;
    mask = 0;
    repeat (LAT) @(posedge clk);
    #1 check("pre_reset", dat_o, 16'd20000);
    #2 rst_n = 0;
    #1 check("mid_reset", dat_o, 16'd0);
    @(posedge clk);
    #1 check("mid_reset_hold", dat_o, 16'd0);
    @(negedge clk);
    rst_n = 1;
    a = 13;
    b = 200;
    repeat (LAT) @(posedge clk);
    #1 check("post_reset", dat_o, 16'd2600);
    for (int i = 0; i < 10000; i++) begin
      sa[i] = 8'($urandom_range(0, 255));
      sb[i] = 8'($urandom_range(0, 255));
      sm[i] = 0;
      se[i] = 16'(sa[i]) * 16'(sb[i]);
      sx[i] = 1;
    end
    run(10000, "random_exact", errs);
    err7f = 0;
    for (int m = 0; m < 128; m++) begin
      for (int i = 0; i < 200; i++) begin
        sa[i] = 8'($urandom_range(0, 255));
        sb[i] = 8'($urandom_range(0, 255));
        sm[i] = 7'(m);
        se[i] = 16'(sa[i]) * 16'(sb[i]);
        sx[i] = 0;
      end
      run(200, "random_bound", errs);
      if (m == 0) check("err_rate_mask0", 16'(errs), 16'd0);
      if (m == 127) err7f = errs;
    end
    n_vec++;
    if (err7f == 0) begin
      n_bad++;
      $display("FAIL err_rate_mask7f: errors=%0d expected nonzero", err7f);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
